// File: rtl/pipe_multiplier.sv
// Pipelined RV-style M-extension multiplier (mul/mulh/mulhsu/mulhu).
// Operand B is split into two partial products up front; their final add sits in the last stage.
module pipe_multiplier #(
  parameter int XLEN   = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [2:0]       funct3,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  mul_out,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);

  localparam int PW = 2*XLEN + 2;
  localparam int H  = XLEN / 2;

  logic              stall, accept;
  logic [STAGES:1]   vld_pipe;

  assign stall      = resp_valid & ~resp_ready;
  assign req_ready  = ~stall;
  assign accept     = req_valid & req_ready & ~flush;
  assign resp_valid = vld_pipe[STAGES];
  assign busy       = |vld_pipe;

  // Operand extension: rs1 unsigned only for mulhu, rs2 unsigned for mulhsu/mulhu.
  logic            a_sgn, b_sgn;
  logic [PW-1:0]   a_x, b_lo_x, b_hi_x, pp_lo_in, pp_hi_in;

  assign a_sgn    = (funct3[1:0] != 2'b11);
  assign b_sgn    = ~funct3[1];
  assign a_x      = {{(PW-XLEN){a_sgn & rs1_data[XLEN-1]}}, rs1_data};
  assign b_lo_x   = {{(PW-H){1'b0}}, rs2_data[H-1:0]};
  assign b_hi_x   = {{(PW-XLEN+H){b_sgn & rs2_data[XLEN-1]}}, rs2_data[XLEN-1:H]};
  // Modulo-2^PW products stay exact because the true product fits in PW bits.
  assign pp_lo_in = a_x * b_lo_x;
  assign pp_hi_in = a_x * b_hi_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe <= '0;
    end else if (flush) begin
      vld_pipe <= '0;
    end else if (!stall) begin
      vld_pipe[1] <= accept;
      for (int k = 2; k <= STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
    end
  end

  logic [PW-1:0]    fin_lo, fin_hi;
  logic [1:0]       fin_op;
  logic [TAG_W-1:0] fin_tag;

  generate
    if (STAGES == 1) begin : g_direct
      assign fin_lo  = pp_lo_in;
      assign fin_hi  = pp_hi_in;
      assign fin_op  = funct3[1:0];
      assign fin_tag = req_tag;
    end else begin : g_pipe
      logic [STAGES-1:1][PW-1:0]    lo_q, hi_q;
      logic [STAGES-1:1][1:0]       op_q;
      logic [STAGES-1:1][TAG_W-1:0] tag_q;

      // Bubbles carry don't-care data; only the valid bits need reset.
      always_ff @(posedge clk) begin
        if (!stall) begin
          lo_q[1]  <= pp_lo_in;
          hi_q[1]  <= pp_hi_in;
          op_q[1]  <= funct3[1:0];
          tag_q[1] <= req_tag;
          for (int k = 2; k < STAGES; k++) begin
            lo_q[k]  <= lo_q[k-1];
            hi_q[k]  <= hi_q[k-1];
            op_q[k]  <= op_q[k-1];
            tag_q[k] <= tag_q[k-1];
          end
        end
      end

      assign fin_lo  = lo_q[STAGES-1];
      assign fin_hi  = hi_q[STAGES-1];
      assign fin_op  = op_q[STAGES-1];
      assign fin_tag = tag_q[STAGES-1];
    end
  endgenerate

  logic [PW-1:0] product;
  logic [2:0]    unused_bits;

  assign product     = fin_lo + (fin_hi << H);
  assign unused_bits = {product[PW-1:2*XLEN], funct3[2]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_out  <= '0;
      resp_tag <= '0;
    end else if (!stall) begin
      mul_out  <= (fin_op == 2'b00) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
      resp_tag <= fin_tag;
    end
  end

endmodule

// File: tb/tb_pipe_multiplier.sv
// Directed + randomized bench for pipe_multiplier; a queue scoreboard fed by an
// arithmetic reference model checks every delivered response.
module tb_pipe_multiplier;

  logic        clk, rst, req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [31:0] rs1_data, rs2_data, mul_out;
  logic [2:0]  funct3;
  logic [4:0]  req_tag, resp_tag;

  pipe_multiplier #(.XLEN(32), .STAGES(3), .TAG_W(5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .funct3(funct3), .req_tag(req_tag),
    .flush(flush), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .mul_out(mul_out), .resp_tag(resp_tag), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [4:0] tag; logic [31:0] res; } sb_t;
  sb_t         sb[$];
  logic [4:0]  dlv_tags[$];
  logic [31:0] cur_exp;
  logic        last_acc;
  int          n_checks, n_fail;

  function automatic logic [31:0] ref_mul(logic [2:0] f, logic [31:0] a, logic [31:0] b);
    longint sa, sbv, p;
    sa  = (f[1:0] == 2'b11) ? longint'({32'b0, a}) : longint'($signed(a));
    sbv = f[1] ? longint'({32'b0, b}) : longint'($signed(b));
    p   = sa * sbv;
    return (f[1:0] == 2'b00) ? p[31:0] : p[63:32];
  endfunction

  task automatic check(string name, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Sample handshakes just after inputs settle, then advance one full cycle.
  task automatic tick();
    logic acc, dlv;
    sb_t  e;
    #1;
    acc = req_valid && req_ready && !flush;
    dlv = resp_valid && resp_ready && !flush;
    if (dlv) begin
      check("resp_expected", sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("resp_tag", resp_tag, e.tag);
        check("mul_out", mul_out, e.res);
        dlv_tags.push_back(resp_tag);
      end
    end
    if (flush) sb.delete();
    else if (acc) sb.push_back('{req_tag, cur_exp});
    last_acc = acc;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] t, input logic [31:0] exp, output int n);
    funct3 = f; rs1_data = a; rs2_data = b; req_tag = t; cur_exp = exp; req_valid = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 50);
    req_valid = 1'b0;
    check("issue_accepted", last_acc, 1);
  endtask

  task automatic issue_rand(input logic [4:0] t);
    logic [2:0]  f;
    logic [31:0] a, b;
    int          n;
    f = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    issue(f, a, b, t, ref_mul(f, a, b), n);
  endtask

  // Issue, then confirm the response shows up exactly three cycles after acceptance.
  task automatic issue_timed(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] t, input logic [31:0] exp);
    int n, lat;
    issue(f, a, b, t, exp, n);
    lat = 1;
    while (!resp_valid && lat < 20) begin tick(); lat++; end
    check("latency", lat, 3);
    check("timed_result", mul_out, exp);
    check("timed_tag", resp_tag, t);
    tick();
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() > 0 || busy) && n < 60) begin tick(); n++; end
    check("drain_empty", sb.size(), 0);
  endtask

  logic [31:0] edge_v[5];

  initial begin
    int n;
    edge_v = '{32'h0, 32'h1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF};
    n_checks = 0; n_fail = 0; last_acc = 1'b0; cur_exp = '0;
    rst = 1'b0; req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    rs1_data = '0; rs2_data = '0; funct3 = '0; req_tag = '0;

    // Reset state
    #12;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_req_ready", req_ready, 1);
    check("rst_mul_out", mul_out, 0);
    check("rst_resp_tag", resp_tag, 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // mul 7 x -3, tag 5
    issue_timed(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5, 32'hFFFF_FFEB);

    // High words back-to-back, no bubbles
    issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, n); check("no_bubble", n, 1);
    issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7, 32'hFFFF_FFFF, n); check("no_bubble", n, 1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd8, 32'hFFFF_FFFE, n); check("no_bubble", n, 1);
    issue(3'b100, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9, 32'h0000_0001, n); check("no_bubble", n, 1);
    drain();

    // Backpressure: four requests, resp_ready low for six cycles
    dlv_tags.delete();
    resp_ready = 1'b0;
    issue_rand(5'd1); issue_rand(5'd2); issue_rand(5'd3);
    funct3 = 3'b011; rs1_data = $urandom; rs2_data = $urandom; req_tag = 5'd4;
    cur_exp = ref_mul(funct3, rs1_data, rs2_data); req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_req_ready", req_ready, 0);
      check("stall_resp_valid", resp_valid, 1);
      check("stall_hold_tag", resp_tag, sb[0].tag);
      check("stall_hold_out", mul_out, sb[0].res);
      tick();
    end
    resp_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (!last_acc && n < 20);
    check("tag4_accepted", last_acc, 1);
    req_valid = 1'b0;
    drain();
    check("bp_count", dlv_tags.size(), 4);
    for (int i = 0; i < 4 && i < dlv_tags.size(); i++) check("bp_order", dlv_tags[i], i + 1);

    // Flush with three in flight, plus a same-cycle request that must be dropped
    resp_ready = 1'b0;
    issue_rand(5'd10); issue_rand(5'd11); issue_rand(5'd12);
    funct3 = 3'b000; rs1_data = 32'd3; rs2_data = 32'd3; req_tag = 5'd13;
    cur_exp = 32'd9; req_valid = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; req_valid = 1'b0;
    check("flush_resp_valid", resp_valid, 0);
    check("flush_busy", busy, 0);
    resp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("flush_no_stale", resp_valid, 0);
    end
    issue_timed(3'b011, 32'h1234_5678, 32'h9ABC_DEF0, 5'd14, ref_mul(3'b011, 32'h1234_5678, 32'h9ABC_DEF0));

    // Async reset mid-cycle with two in flight
    issue_rand(5'd20); issue_rand(5'd21);
    #1 rst = 1'b0;
    #1;
    check("arst_resp_valid", resp_valid, 0);
    check("arst_busy", busy, 0);
    check("arst_req_ready", req_ready, 1);
    check("arst_mul_out", mul_out, 0);
    check("arst_resp_tag", resp_tag, 0);
    sb.delete();
    #1 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("arst_no_stale", resp_valid, 0);
    end
    issue_timed(3'b001, 32'hFFFF_FFF0, 32'h0000_0100, 5'd22, 32'hFFFF_FFFF);

    // Randomized traffic with random backpressure and corner operands
    dlv_tags.delete();
    last_acc = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (!req_valid || last_acc) begin
        req_valid = ($urandom_range(0, 3) != 0);
        rs1_data  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
        rs2_data  = ($urandom_range(0, 3) == 0) ? edge_v[$urandom_range(0, 4)] : $urandom;
        funct3    = 3'($urandom_range(0, 7));
        req_tag   = 5'($urandom);
        cur_exp   = ref_mul(funct3, rs1_data, rs2_data);
      end
      resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();
    check("busy_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_multiplier.md
PIPE_MULTIPLIER -- requirements
Module: pipe_multiplier

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, giving the operand and result width in bits (legal values: 32, 64).
REQ-002 The block SHALL have parameter STAGES, default 3, giving the number of pipeline stages from acceptance to response (legal values: 1 to 4).
REQ-003 The block SHALL have parameter TAG_W, default 5, giving the width of the request tag (e.g. destination register).
REQ-004 Port clk  in  1  is the single clock; all state SHALL update on its rising edge.
REQ-005 Port rst  in  1  is the reset: asynchronous, active-low.
REQ-006 Port req_valid  in  1  indicates a request is presented.
REQ-007 Port req_ready  out  1  indicates the block can accept a request this cycle.
REQ-008 Port rs1_data  in  XLEN  is operand A.
REQ-009 Port rs2_data  in  XLEN  is operand B.
REQ-010 Port funct3  in  3  is the operation code: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu; bit 2 is ignored.
REQ-011 Port req_tag  in  TAG_W  is an opaque tag carried with the request.
REQ-012 Port flush  in  1  kills all in-flight requests.
REQ-013 Port resp_valid  out  1  indicates a result is presented.
REQ-014 Port resp_ready  in  1  indicates the consumer accepts the result.
REQ-015 Port mul_out  out  XLEN  is the result.
REQ-016 Port resp_tag  out  TAG_W  is the tag of the presented result.
REQ-017 Port busy  out  1  is high when any stage holds a valid request.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid and req_ready are both high and flush is low.
REQ-019 Operand extension rules:
- Each operand SHALL be extended to XLEN+1 bits: sign-extended if signed, zero-extended if unsigned.
- mul and mulh: both operands signed.
- mulhsu: rs1 signed, rs2 unsigned.
- mulhu: both operands unsigned.
REQ-020 The product SHALL be the exact two's-complement product of the extended operands, at least 2*XLEN+2 bits wide, with no separate negate step.
REQ-021 Result selection: mul SHALL return product bits [XLEN-1:0]; mulh, mulhsu and mulhu SHALL return product bits [2*XLEN-1:XLEN].
REQ-022 An accepted request SHALL appear on resp_valid exactly STAGES cycles later when no stall occurs.
REQ-023 Partial-product reduction MAY be split across stages; the final carry-propagate add SHALL be in the last stage.
REQ-024 Each stage SHALL hold a valid bit, funct3 and the tag; resp_valid SHALL equal the last-stage valid bit.
REQ-025 Stall rule:
- stall = resp_valid AND NOT resp_ready.
- While stalled, all stages SHALL hold their contents.
- req_ready SHALL equal NOT stall, a combinational function of resp_valid and resp_ready only.
REQ-026 Throughput SHALL be one request per cycle with no bubbles when resp_ready is held high.
REQ-027 Results SHALL be delivered in acceptance order, each exactly once.
REQ-028 mul_out and resp_tag SHALL be stable while resp_valid is high and resp_ready is low.
REQ-029 Flush rules:
- flush high SHALL clear every stage valid bit at that edge.
- A request presented in the same cycle SHALL be dropped.
- resp_valid SHALL be low in the following cycle.
- Flush SHALL take priority over stall and over acceptance.
REQ-030 busy SHALL be the OR of all stage valid bits.

Reset
REQ-031 While rst is low, all stage valid bits SHALL clear asynchronously, and resp_valid and busy SHALL read 0.
REQ-032 While rst is low, req_ready SHALL read 1.
REQ-033 Reset values of outputs:
- mul_out and resp_tag SHALL reset to 0.
- Datapath registers other than the valid bits MAY be left without reset.
REQ-034 A request accepted before reset asserts mid-operation SHALL never be presented after rst deasserts.

Verification
REQ-035 mul: 7 x 0xFFFFFFFD (-3), tag 5 -> mul_out 0xFFFFFFEB, resp_tag 5, exactly 3 cycles after acceptance.
REQ-036 Signed and mixed-sign high words:
- mulh 0x80000000 x 0x80000000 -> 0x40000000.
- mulhsu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-037 mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; mul on the same operands -> 0x00000001.
REQ-038 Backpressure:
- Stimulus: 4 back-to-back requests with tags 1-4; resp_ready low for 6 cycles, then high.
- Required: req_ready low during the stall; tags 1, 2, 3, 4 delivered in order, none lost or duplicated.
REQ-039 Flush with 3 requests in flight: flush high for 1 cycle -> resp_valid stays 0 and busy becomes 0; the next request returns the correct result after 3 cycles.
REQ-040 Async reset: rst pulsed low between clock edges with 2 requests in flight -> resp_valid and busy drop immediately, and no stale result appears after release.
